// File: rtl/onehot_scan_encoder.sv
// onehot_scan_encoder: serialises a 16-bit request vector into one 4-bit index code per set bit.
// Latency: first code beat is valid the cycle after the vector is accepted; a vector with p set bits takes p beats.
// Backpressure: out_ready low holds the current beat stable; in_ready follows out_ready on the last beat so vectors chain without a bubble.
// Optional build macro ENC_MSB_FIRST_EN: scan highest set index first (default is lowest first).
module onehot_scan_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_code,
  output logic        out_last,
  output logic [3:0]  out_beat,
  output logic        zero_seen
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] pending;
  logic [3:0]  beat;

  logic [3:0]  sel_idx;
  logic [15:0] sel_mask;
  logic        single;
  logic        in_fire;
  logic        out_fire;

  // Pick the index of the next request to emit from the remaining pending bits
  always_comb begin
    sel_idx = 4'h0;
`ifdef ENC_MSB_FIRST_EN
    // Ascending walk: the last match wins, so the highest set index is chosen
    for (int k = 0; k < 16; k++) begin
      if (pending[k]) sel_idx = 4'(k);
    end
`else
    // Descending walk: the last match wins, so the lowest set index is chosen
    for (int k = 15; k >= 0; k--) begin
      if (pending[k]) sel_idx = 4'(k);
    end
`endif
    sel_mask = 16'h0001 << sel_idx;
  end

  // Output beat and handshake decode; code bits are reversed so the downstream decoder lights bit k
  always_comb begin
    single    = (pending != 16'h0000) && ((pending & (pending - 16'd1)) == 16'h0000);
    out_valid = (state == SCAN);
    out_code  = out_valid ? {sel_idx[0], sel_idx[1], sel_idx[2], sel_idx[3]} : 4'h0;
    out_last  = out_valid & single;
    out_beat  = out_valid ? beat : 4'h0;
    in_ready  = (state == IDLE) | (out_ready & out_last);
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
  end

  // Scan state machine: load on accept, retire one pending bit per accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= 16'h0000;
      beat      <= 4'h0;
      zero_seen <= 1'b0;
    end else begin
      zero_seen <= in_fire && (in_vec == 16'h0000);
      if (in_fire) begin
        // Covers both the IDLE accept and the chained accept on a last beat
        pending <= in_vec;
        beat    <= 4'h0;
        state   <= (in_vec != 16'h0000) ? SCAN : IDLE;
      end else if (out_fire) begin
        pending <= pending & ~sel_mask;
        beat    <= beat + 4'd1;
        if (out_last) state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Bench for onehot_scan_encoder: directed test-plan steps followed by a random run,
// all checked cycle by cycle against a queue of expected beats built from the vector bits.
module tb_onehot_scan_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_code;
  logic        out_last;
  logic [3:0]  out_beat;
  logic        zero_seen;

  onehot_scan_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .out_beat  (out_beat),
    .zero_seen (zero_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [3:0] beat;
    logic       last;
  } beat_t;

  beat_t       exp_q[$];
  logic        exp_zero;
  int          n_cmp;
  int          n_err;
  logic [3:0]  seen_code;
  logic        seen_valid;
  logic [15:0] cover_mask;

  function automatic logic [3:0] rev4(input logic [3:0] c);
    return {c[0], c[1], c[2], c[3]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected beats of a vector: one per set bit, in scan order, last flagged on the final one
  task automatic push_vec(input logic [15:0] v);
    beat_t b;
    int    n;
    int    total;
    n     = 0;
    total = $countones(v);
`ifdef ENC_MSB_FIRST_EN
    for (int k = 15; k >= 0; k--) begin
`else
    for (int k = 0; k < 16; k++) begin
`endif
      if (v[k]) begin
        b.code = rev4(4'(k));
        b.beat = 4'(n);
        b.last = (n == total - 1);
        exp_q.push_back(b);
        n++;
      end
    end
  endtask

  // One clock cycle: apply inputs, compare against the model, advance the model across the edge
  task automatic cycle(input logic iv, input logic [15:0] v, input logic ordy);
    logic  exp_rdy;
    beat_t h;
    in_valid  = iv;
    in_vec    = v;
    out_ready = ordy;
    #1;
    exp_rdy = (exp_q.size() == 0) || (ordy && exp_q.size() == 1);
    check("in_ready", 16'(in_ready), 16'(exp_rdy));
    check("out_valid", 16'(out_valid), 16'(exp_q.size() != 0));
    check("zero_seen", 16'(zero_seen), 16'(exp_zero));
    seen_valid = out_valid;
    seen_code  = out_code;
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("out_code", 16'(out_code), 16'(h.code));
      check("out_beat", 16'(out_beat), 16'(h.beat));
      check("out_last", 16'(out_last), 16'(h.last));
    end
    exp_zero = 1'b0;
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (iv && exp_rdy) begin
      if (v == 16'h0000) exp_zero = 1'b1;
      else push_vec(v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 16'(in_ready), 16'h1);
    check({tag, "_out_valid"}, 16'(out_valid), 16'h0);
    check({tag, "_out_code"}, 16'(out_code), 16'h0);
    check({tag, "_out_last"}, 16'(out_last), 16'h0);
    check({tag, "_out_beat"}, 16'(out_beat), 16'h0);
    check({tag, "_zero_seen"}, 16'(zero_seen), 16'h0);
  endtask

  initial begin
    logic [15:0] rv;
    clk       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 16'h0000;
    out_ready = 1'b0;
    n_cmp     = 0;
    n_err     = 0;
    exp_zero  = 1'b0;

    // Reset values
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-vector: beat 0 taken, then reset drops the rest
    cycle(1'b1, 16'h0012, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_zero = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1);

    // Basic scan of 16'h0012
    cycle(1'b1, 16'h0012, 1'b1);
`ifdef ENC_MSB_FIRST_EN
    check("basic_first_code", 16'(out_code), 16'h2);
`else
    check("basic_first_code", 16'(out_code), 16'h8);
`endif
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);

    // Backpressure on 16'h8001: current beat held for 5 stalled cycles
    cycle(1'b1, 16'h8001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 16'h0000, 1'b0);
`ifdef ENC_MSB_FIRST_EN
      check("stall_code", 16'(out_code), 16'hF);
`else
      check("stall_code", 16'(out_code), 16'h0);
`endif
      check("stall_last", 16'(out_last), 16'h0);
    end
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);

    // Full vector: 16 beats covering every index once
    cover_mask = 16'h0000;
    cycle(1'b1, 16'hFFFF, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 16'h0000, 1'b1);
      if (seen_valid) cover_mask = cover_mask | (16'h0001 << rev4(seen_code));
    end
    check("full_cover", cover_mask, 16'hFFFF);
    cycle(1'b0, 16'h0000, 1'b1);

    // Zero vector, then 16'h0004 chained into 16'h0100 on its last beat
    cycle(1'b1, 16'h0000, 1'b1);
    check("zero_pulse", 16'(zero_seen), 16'h1);
    cycle(1'b1, 16'h0004, 1'b1);
    check("zero_pulse_gone", 16'(zero_seen), 16'h0);
    check("chain_first_code", 16'(out_code), 16'h4);
    cycle(1'b1, 16'h0100, 1'b1);
    check("chain_second_code", 16'(out_code), 16'h1);
    check("chain_no_bubble", 16'(out_valid), 16'h1);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);

    // Random traffic with mixed density, zero vectors and backpressure
    for (int i = 0; i < 2000; i++) begin
      rv = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rv = rv & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) == 0) rv = 16'h0000;
      cycle(1'($urandom_range(0, 1)), rv, ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
